// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: FSM state encoding, funct3 access codes and op classification for the memory stage
package mem_access_stage_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] FAULT  = 2'd2;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // State an op entering M moves the FSM to: ACCESS if legal and aligned, FAULT if not, IDLE for non-memory ops.
    function automatic logic [1:0] op_state(input logic rd, input logic wr, input logic [2:0] f3, input logic [1:0] a);
        logic legal, mis;
        legal = wr ? (f3 == SB || f3 == SH || f3 == SW)
                   : (f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
        mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return !(rd || wr) ? IDLE : (legal && !mis) ? ACCESS : FAULT;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// mem_access_stage_load_align: selects the load lane from the read word and sign/zero extends it
//   rdata   in  32  word returned by data memory
//   addr_lo in  2   byte offset of the access
//   funct3  in  3   load size/sign
//   data    out 32  aligned, extended load result
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [15:0] lane;

    assign lane = 16'(rdata >> {addr_lo, 3'b000});

    always_comb
        data = funct3 == LB  ? {{24{lane[7]}}, lane[7:0]}   :
               funct3 == LH  ? {{16{lane[15]}}, lane}       :
               funct3 == LBU ? {24'd0, lane[7:0]}           :
               funct3 == LHU ? {16'd0, lane}                :
                               rdata;

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RISC-V MEM stage with EX/MEM and MEM/WB registers and a req/ready data-memory port
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_OUT_EX,
  input  logic [31:0] REG_DATA2_EX_FINAL,
  input  logic [2:0]  FUNCT3_EX,
  input  logic [4:0]  RD_EX,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        STALL_MEM,
  output logic        MEM_FAULT,
  output logic [31:0] ALU_OUT_MEM,
  output logic [4:0]  RD_MEM,
  output logic        RegWrite_MEM,
  output logic [31:0] ALU_DATA_WB,
  output logic [4:0]  RD_WB,
  output logic        RegWrite_WB
);
  logic [1:0]  state, state_nx;
  logic [31:0] m_wdata, load_data;
  logic [2:0]  m_funct3;
  logic        m_memtoreg, m_memwrite, wb_ld, timeout;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign timeout = wait_cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) wait_cnt <= '0;
    else       wait_cnt <= STALL_MEM ? wait_cnt + 8'd1 : '0;
`else
  assign timeout = 1'b0;
`endif
  assign dmem_req  = state == ACCESS;
  assign dmem_we   = m_memwrite;
  assign dmem_addr = {ALU_OUT_MEM[31:2], 2'b00};
  assign STALL_MEM = state == ACCESS && !dmem_ready;
  assign MEM_FAULT = state == FAULT;
  assign wb_ld     = !STALL_MEM && !MEM_FAULT;
  always_comb begin
    dmem_be    = !m_memwrite    ? 4'b1111 :
                 m_funct3 == SB ? 4'b0001 << ALU_OUT_MEM[1:0] :
                 m_funct3 == SH ? 4'b0011 << {ALU_OUT_MEM[1], 1'b0} :
                                  4'b1111;
    dmem_wdata = m_funct3 == SB ? {4{m_wdata[7:0]}} :
                 m_funct3 == SH ? {2{m_wdata[15:0]}} :
                                  m_wdata;
    state_nx   = STALL_MEM ? (timeout ? FAULT : ACCESS)
                           : op_state(MemRead_EX, MemWrite_EX, FUNCT3_EX, ALU_OUT_EX[1:0]);
  end
  mem_access_stage_load_align load_align (
    .rdata   (dmem_rdata),
    .addr_lo (ALU_OUT_MEM[1:0]),
    .funct3  (m_funct3),
    .data    (load_data)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ALU_OUT_MEM  <= '0;
      m_wdata      <= '0;
      m_funct3     <= '0;
      RD_MEM       <= '0;
      RegWrite_MEM <= 1'b0;
      m_memtoreg   <= 1'b0;
      m_memwrite   <= 1'b0;
      ALU_DATA_WB  <= '0;
      RD_WB        <= '0;
      RegWrite_WB  <= 1'b0;
    end else begin
      state <= state_nx;
      if (!STALL_MEM) begin
        ALU_OUT_MEM  <= ALU_OUT_EX;
        m_wdata      <= REG_DATA2_EX_FINAL;
        m_funct3     <= FUNCT3_EX;
        RD_MEM       <= RD_EX;
        RegWrite_MEM <= RegWrite_EX;
        m_memtoreg   <= MemtoReg_EX;
        m_memwrite   <= MemWrite_EX;
      end
      ALU_DATA_WB <= !wb_ld ? '0 : m_memtoreg ? load_data : ALU_OUT_MEM;
      RD_WB       <= wb_ld ? RD_MEM : '0;
      RegWrite_WB <= wb_ld && RegWrite_MEM;
    end
  end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for the memory stage with a programmable-latency memory responder
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ALU_OUT_EX = '0, REG_DATA2_EX_FINAL = '0;
  logic [2:0]  FUNCT3_EX = '0;
  logic [4:0]  RD_EX = '0;
  logic        RegWrite_EX = 0, MemtoReg_EX = 0, MemRead_EX = 0, MemWrite_EX = 0;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        STALL_MEM, MEM_FAULT, RegWrite_MEM, RegWrite_WB;
  logic [31:0] ALU_OUT_MEM, ALU_DATA_WB;
  logic [4:0]  RD_MEM, RD_WB;
  int total = 0, bad = 0;
  int wait_cfg = 0, wcnt = 0;
  logic [31:0] rdata_cfg = '0;
  int req_n = 0, stall_n = 0, fault_n = 0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_wd = '0, last_addr = '0, stall_alu = '0;
  logic        last_we = 1'b0;
  logic [36:0] exp_q[$];
  assign dmem_rdata = rdata_cfg;
  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ALU_OUT_EX(ALU_OUT_EX), .REG_DATA2_EX_FINAL(REG_DATA2_EX_FINAL),
    .FUNCT3_EX(FUNCT3_EX), .RD_EX(RD_EX),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
    .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .STALL_MEM(STALL_MEM), .MEM_FAULT(MEM_FAULT),
    .ALU_OUT_MEM(ALU_OUT_MEM), .RD_MEM(RD_MEM), .RegWrite_MEM(RegWrite_MEM),
    .ALU_DATA_WB(ALU_DATA_WB), .RD_WB(RD_WB), .RegWrite_WB(RegWrite_WB)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, got, exp);
    end
  endtask
  always begin
    @(posedge clk);
    #1;
    if (dmem_req) begin
      dmem_ready = wcnt == wait_cfg;
      wcnt = dmem_ready ? 0 : wcnt + 1;
    end else begin
      dmem_ready = 1'b0;
      wcnt = 0;
    end
  end
  always @(negedge clk) begin
    logic [36:0] e;
    if (dmem_req) begin
      req_n++;
      last_be = dmem_be;
      last_wd = dmem_wdata;
      last_we = dmem_we;
      last_addr = dmem_addr;
    end
    if (STALL_MEM) begin
      stall_n++;
      stall_alu = ALU_OUT_MEM;
    end
    if (MEM_FAULT) fault_n++;
    if (RegWrite_WB) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected rd=%0d data=%h", RD_WB, ALU_DATA_WB);
      end else begin
        e = exp_q.pop_front();
        chk("wb_rd", 32'(RD_WB), 32'(e[36:32]));
        chk("wb_data", ALU_DATA_WB, e[31:0]);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic set_ex(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3, input logic [4:0] rd,
                        input logic rw, input logic m2r, input logic mr, input logic mw);
    ALU_OUT_EX = a; REG_DATA2_EX_FINAL = d; FUNCT3_EX = f3; RD_EX = rd;
    RegWrite_EX = rw; MemtoReg_EX = m2r; MemRead_EX = mr; MemWrite_EX = mw;
  endtask
  task automatic go(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3, input logic [4:0] rd,
                    input logic rw, input logic m2r, input logic mr, input logic mw);
    set_ex(a, d, f3, rd, rw, m2r, mr, mw);
    tick();
    set_ex('0, '0, '0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 50 && STALL_MEM; i++) tick();
    chk("stall_bound", 32'(STALL_MEM), 32'd0);
    tick();
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int r0, s0, f0;
    tick();
    tick();
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_stall", 32'(STALL_MEM), 0);
    chk("rst_fault", 32'(MEM_FAULT), 0);
    chk("rst_rw_wb", 32'(RegWrite_WB), 0);
    chk("rst_rw_mem", 32'(RegWrite_MEM), 0);
    chk("rst_alu_mem", ALU_OUT_MEM, 0);
    chk("rst_data_wb", ALU_DATA_WB, 0);
    chk("rst_rd", 32'({RD_MEM, RD_WB}), 0);
    reset = 1'b0;
    tick();
    r0 = req_n; s0 = stall_n;
    exp_q.push_back({5'd5, 32'h0000_0010});
    go(32'h10, 0, 3'b000, 5'd5, 1, 0, 0, 0);
    chk("add_stall", 32'(stall_n - s0), 0);
    chk("add_req", 32'(req_n - r0), 0);
    r0 = req_n; s0 = stall_n;
    rdata_cfg = 32'h80AB_CDEF;
    exp_q.push_back({5'd6, 32'hFFFF_FF80});
    go(32'h103, 0, 3'b000, 5'd6, 1, 1, 1, 0);
    chk("lb_be", 32'(last_be), 32'hF);
    chk("lb_addr", last_addr, 32'h100);
    chk("lb_req", 32'(req_n - r0), 1);
    chk("lb_stall", 32'(stall_n - s0), 0);
    go(32'h102, 32'h1234_BEEF, 3'b001, 5'd0, 0, 0, 0, 1);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_wdata", last_wd, 32'hBEEF_BEEF);
    chk("sh_we", 32'(last_we), 1);
    r0 = req_n; f0 = fault_n;
    go(32'h102, 0, 3'b010, 5'd9, 1, 1, 1, 0);
    chk("lwmis_req", 32'(req_n - r0), 0);
    chk("lwmis_fault", 32'(fault_n - f0), 1);
    r0 = req_n; s0 = stall_n;
    wait_cfg = 3;
    rdata_cfg = 32'hDEAD_BEEF;
    exp_q.push_back({5'd7, 32'hDEAD_BEEF});
    go(32'h200, 0, 3'b010, 5'd7, 1, 1, 1, 0);
    chk("lww_stall", 32'(stall_n - s0), 3);
    chk("lww_req", 32'(req_n - r0), 4);
    chk("lww_held", stall_alu, 32'h200);
    wait_cfg = 0;
    rdata_cfg = 32'h8001_1234;
    exp_q.push_back({5'd8, 32'h0000_8001});
    go(32'h202, 0, 3'b101, 5'd8, 1, 1, 1, 0);
    exp_q.push_back({5'd10, 32'hFFFF_8001});
    go(32'h202, 0, 3'b001, 5'd10, 1, 1, 1, 0);
    rdata_cfg = 32'h0000_9A00;
    exp_q.push_back({5'd11, 32'h0000_009A});
    go(32'h101, 0, 3'b100, 5'd11, 1, 1, 1, 0);
    go(32'h101, 32'h0000_0055, 3'b000, 5'd0, 0, 0, 0, 1);
    chk("sb_be", 32'(last_be), 32'h2);
    chk("sb_wdata", last_wd, 32'h5555_5555);
    go(32'h10, 32'hCAFE_F00D, 3'b010, 5'd0, 0, 0, 0, 1);
    chk("sw_be", 32'(last_be), 32'hF);
    chk("sw_wdata", last_wd, 32'hCAFE_F00D);
    r0 = req_n; f0 = fault_n;
    go(32'h0, 32'h1, 3'b011, 5'd0, 0, 0, 0, 1);
    chk("ill_req", 32'(req_n - r0), 0);
    chk("ill_fault", 32'(fault_n - f0), 1);
    wait_cfg = 255;
    set_ex(32'h400, 0, 3'b010, 5'd12, 1, 1, 1, 0);
    tick();
    set_ex('0, '0, '0, '0, 0, 0, 0, 0);
    tick();
    chk("mid_req_before", 32'(dmem_req), 1);
    reset = 1'b1;
    #1;
    chk("mid_req_after", 32'(dmem_req), 0);
    chk("mid_stall_after", 32'(STALL_MEM), 0);
    tick();
    reset = 1'b0;
    tick();
`ifdef MEM_TIMEOUT_EN
    r0 = req_n; s0 = stall_n; f0 = fault_n;
    go(32'h300, 0, 3'b010, 5'd13, 1, 1, 1, 0);
    chk("to_req", 32'(req_n - r0), 4);
    chk("to_stall", 32'(stall_n - s0), 4);
    chk("to_fault", 32'(fault_n - f0), 1);
    chk("to_stall_rel", 32'(STALL_MEM), 0);
`endif
    wait_cfg = 0;
    tick();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
